// File: rtl/cavlc_bis_scheduler.sv
// CAVLC bitstream scheduler: latches one encoder field bundle and emits its
// non-empty fields as right-aligned chunks (at most 32 bits) to a bitstream
// writer over a valid/ready handshake. Counts completed blocks.
//
// state | meaning
// IDLE  | waiting for a bundle, enc_ready=1
// CT    | emitting coeff_token
// T1    | emitting trailing-ones sign flags
// LVH   | emitting levelcode bits above bit 31
// LVL   | emitting levelcode bits 31..0
// TZ    | emitting total_zeros
// RB    | emitting run_before
// DONE  | one-cycle block completion, blk_done=1
module cavlc_bis_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        enc_valid,
    output logic        enc_ready,
    input  logic [15:0] coeff_token_code,
    input  logic [4:0]  coeff_token_bit,
    input  logic [2:0]  trailingones_code,
    input  logic [3:0]  trailingones_bit,
    input  logic [49:0] levelcode_code,
    input  logic [5:0]  levelcode_bit,
    input  logic [8:0]  totalzero_code,
    input  logic [3:0]  totalzero_bit,
    input  logic [24:0] runbefore_code,
    input  logic [4:0]  runbefore_bit,
    input  logic [4:0]  total_coeff_cnt,
    output logic        bs_valid,
    input  logic        bs_ready,
    output logic [31:0] bs_code,
    output logic [5:0]  bs_len,
    output logic        bs_last,
    output logic        blk_done,
    output logic [15:0] blk_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CT   = 3'd1,
        T1   = 3'd2,
        LVH  = 3'd3,
        LVL  = 3'd4,
        TZ   = 3'd5,
        RB   = 3'd6,
        DONE = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ct_code_q;
    logic [4:0]  ct_bit_q;
    logic [2:0]  t1_code_q;
    logic [3:0]  t1_bit_q;
    logic [49:0] lv_code_q;
    logic [5:0]  lv_bit_q;
    logic [8:0]  tz_code_q;
    logic [3:0]  tz_bit_q;
    logic [24:0] rb_code_q;
    logic [4:0]  rb_bit_q;
    logic [4:0]  tc_q;
    logic [15:0] blk_cnt_q, blk_cnt_d;

    logic [5:0]  ne_in, ne_q;
    state_t      nxt_chunk;
    logic [31:0] chunk_code;
    logic [5:0]  chunk_len;
    logic        chunk_valid, chunk_last, done_c, ready_c;

    // Bit k set when chunk k (CT,T1,LVH,LVL,TZ,RB order) carries any bits.
    // TZ is never coded for an all-zero block or a full block of 16 coeffs.
    function automatic logic [5:0] nonempty(input logic [4:0] ct_b, input logic [3:0] t1_b,
                                            input logic [5:0] lv_b, input logic [3:0] tz_b,
                                            input logic [4:0] rb_b, input logic [4:0] tc);
        logic [5:0] ne;
        ne[0] = (ct_b != 5'd0);
        ne[1] = (t1_b != 4'd0);
        ne[2] = (lv_b > 6'd32);
        ne[3] = (lv_b != 6'd0);
        ne[4] = (tz_b != 4'd0) && (tc != 5'd0) && (tc != 5'd16);
        ne[5] = (rb_b != 5'd0);
        return ne;
    endfunction

    // First non-empty chunk at index >= start, else DONE.
    function automatic state_t first_from(input logic [5:0] ne, input logic [2:0] start);
        state_t s;
        s = DONE;
        for (int k = 5; k >= 0; k--) begin
            if ((3'(k) >= start) && ne[k]) s = state_t'(3'(k + 1));
        end
        return s;
    endfunction

    // Clear any bits above the chunk length so the writer sees clean codes.
    function automatic logic [31:0] trim(input logic [31:0] c, input logic [5:0] len);
        logic [32:0] m;
        m = (33'd1 << len) - 33'd1;
        return c & m[31:0];
    endfunction

    assign ne_in = nonempty(coeff_token_bit, trailingones_bit, levelcode_bit,
                            totalzero_bit, runbefore_bit, total_coeff_cnt);
    assign ne_q  = nonempty(ct_bit_q, t1_bit_q, lv_bit_q, tz_bit_q, rb_bit_q, tc_q);

    // Next-state and chunk selection for the current state.
    always_comb begin
        state_d     = state_q;
        blk_cnt_d   = blk_cnt_q;
        ready_c     = 1'b0;
        chunk_valid = 1'b0;
        chunk_code  = 32'd0;
        chunk_len   = 6'd0;
        done_c      = 1'b0;
        nxt_chunk   = first_from(ne_q, state_q);
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (enc_valid) state_d = first_from(ne_in, 3'd0);
            end
            CT: begin
                chunk_code = {16'd0, ct_code_q};
                chunk_len  = {1'b0, ct_bit_q};
            end
            T1: begin
                chunk_code = {29'd0, t1_code_q};
                chunk_len  = {2'd0, t1_bit_q};
            end
            LVH: begin
                chunk_code = {14'd0, lv_code_q[49:32]};
                chunk_len  = lv_bit_q - 6'd32;
            end
            LVL: begin
                chunk_code = lv_code_q[31:0];
                chunk_len  = (lv_bit_q > 6'd32) ? 6'd32 : lv_bit_q;
            end
            TZ: begin
                chunk_code = {23'd0, tz_code_q};
                chunk_len  = {2'd0, tz_bit_q};
            end
            RB: begin
                chunk_code = {7'd0, rb_code_q};
                chunk_len  = {1'b0, rb_bit_q};
            end
            DONE: begin
                done_c    = 1'b1;
                blk_cnt_d = blk_cnt_q + 16'd1;
                state_d   = IDLE;
            end
        endcase
        if (state_q != IDLE && state_q != DONE) begin
            chunk_valid = 1'b1;
            if (bs_ready) state_d = nxt_chunk;
        end
    end

    // Outputs are forced quiet while rst is high, even before the reset edge.
    assign enc_ready = ready_c & ~rst;
    assign bs_valid  = chunk_valid & ~rst;
    assign bs_code   = rst ? 32'd0 : trim(chunk_code, chunk_len);
    assign bs_len    = rst ? 6'd0 : chunk_len;
    assign bs_last   = chunk_valid & (nxt_chunk == DONE) & ~rst;
    assign blk_done  = done_c & ~rst;
    assign blk_cnt   = blk_cnt_q;

    // State, block counter and bundle latch; fields captured only on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            blk_cnt_q <= 16'd0;
            ct_code_q <= '0;
            ct_bit_q  <= '0;
            t1_code_q <= '0;
            t1_bit_q  <= '0;
            lv_code_q <= '0;
            lv_bit_q  <= '0;
            tz_code_q <= '0;
            tz_bit_q  <= '0;
            rb_code_q <= '0;
            rb_bit_q  <= '0;
            tc_q      <= '0;
        end else begin
            state_q   <= state_d;
            blk_cnt_q <= blk_cnt_d;
            if (state_q == IDLE && enc_valid) begin
                ct_code_q <= coeff_token_code;
                ct_bit_q  <= coeff_token_bit;
                t1_code_q <= trailingones_code;
                t1_bit_q  <= trailingones_bit;
                lv_code_q <= levelcode_code;
                lv_bit_q  <= levelcode_bit;
                tz_code_q <= totalzero_code;
                tz_bit_q  <= totalzero_bit;
                rb_code_q <= runbefore_code;
                rb_bit_q  <= runbefore_bit;
                tc_q      <= total_coeff_cnt;
            end
        end
    end

endmodule

// File: tb/tb_cavlc_bis_scheduler.sv
// Directed and randomized bench for cavlc_bis_scheduler with a chunk scoreboard.
module tb_cavlc_bis_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        enc_valid;
    logic        enc_ready;
    logic [15:0] coeff_token_code;
    logic [4:0]  coeff_token_bit;
    logic [2:0]  trailingones_code;
    logic [3:0]  trailingones_bit;
    logic [49:0] levelcode_code;
    logic [5:0]  levelcode_bit;
    logic [8:0]  totalzero_code;
    logic [3:0]  totalzero_bit;
    logic [24:0] runbefore_code;
    logic [4:0]  runbefore_bit;
    logic [4:0]  total_coeff_cnt;
    logic        bs_valid;
    logic        bs_ready;
    logic [31:0] bs_code;
    logic [5:0]  bs_len;
    logic        bs_last;
    logic        blk_done;
    logic [15:0] blk_cnt;

    cavlc_bis_scheduler dut (
        .clk(clk), .rst(rst), .enc_valid(enc_valid), .enc_ready(enc_ready),
        .coeff_token_code(coeff_token_code), .coeff_token_bit(coeff_token_bit),
        .trailingones_code(trailingones_code), .trailingones_bit(trailingones_bit),
        .levelcode_code(levelcode_code), .levelcode_bit(levelcode_bit),
        .totalzero_code(totalzero_code), .totalzero_bit(totalzero_bit),
        .runbefore_code(runbefore_code), .runbefore_bit(runbefore_bit),
        .total_coeff_cnt(total_coeff_cnt), .bs_valid(bs_valid), .bs_ready(bs_ready),
        .bs_code(bs_code), .bs_len(bs_len), .bs_last(bs_last),
        .blk_done(blk_done), .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] code;
        logic [5:0]  len;
        logic        last;
    } chunk_t;

    typedef struct packed {
        logic [15:0] ct_code; logic [4:0] ct_bit;
        logic [2:0]  t1_code; logic [3:0] t1_bit;
        logic [49:0] lv_code; logic [5:0] lv_bit;
        logic [8:0]  tz_code; logic [3:0] tz_bit;
        logic [24:0] rb_code; logic [4:0] rb_bit;
        logic [4:0]  tc;
    } bundle_t;

    chunk_t  sb_q[$];
    int      checks = 0;
    int      failures = 0;
    int      done_seen = 0;
    int      exp_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bundle_t mk(input logic [15:0] ctc, input logic [4:0] ctb,
                                   input logic [2:0] t1c, input logic [3:0] t1b,
                                   input logic [49:0] lvc, input logic [5:0] lvb,
                                   input logic [8:0] tzc, input logic [3:0] tzb,
                                   input logic [24:0] rbc, input logic [4:0] rbb,
                                   input logic [4:0] tc);
        bundle_t b;
        b.ct_code = ctc; b.ct_bit = ctb; b.t1_code = t1c; b.t1_bit = t1b;
        b.lv_code = lvc; b.lv_bit = lvb; b.tz_code = tzc; b.tz_bit = tzb;
        b.rb_code = rbc; b.rb_bit = rbb; b.tc = tc;
        return b;
    endfunction

    task automatic drive(input bundle_t b);
        coeff_token_code = b.ct_code; coeff_token_bit = b.ct_bit;
        trailingones_code = b.t1_code; trailingones_bit = b.t1_bit;
        levelcode_code = b.lv_code; levelcode_bit = b.lv_bit;
        totalzero_code = b.tz_code; totalzero_bit = b.tz_bit;
        runbefore_code = b.rb_code; runbefore_bit = b.rb_bit;
        total_coeff_cnt = b.tc;
    endtask

    function automatic bundle_t rnd_bundle();
        bundle_t b;
        b.ct_code = 16'($urandom); b.ct_bit = 5'($urandom_range(0, 16));
        b.t1_code = 3'($urandom);  b.t1_bit = 4'($urandom_range(0, 3));
        b.lv_code = 50'({$urandom(), $urandom()}); b.lv_bit = 6'($urandom_range(0, 50));
        b.tz_code = 9'($urandom);  b.tz_bit = 4'($urandom_range(0, 9));
        b.rb_code = 25'($urandom); b.rb_bit = 5'($urandom_range(0, 25));
        b.tc = 5'($urandom_range(0, 16));
        return b;
    endfunction

    task automatic expect_chunk(input logic [31:0] code, input logic [5:0] len, input logic last);
        chunk_t c;
        c.code = code; c.len = len; c.last = last;
        sb_q.push_back(c);
    endtask

    function automatic logic [31:0] keep(input logic [63:0] c, input int n);
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        return c[31:0] & m[31:0];
    endfunction

    // Reference model: the fields that carry bits, in emission order.
    task automatic model_push(input bundle_t b);
        chunk_t tmp[$];
        chunk_t c;
        int     lo;
        c.last = 1'b0;
        if (b.ct_bit != 0) begin c.code = keep(64'(b.ct_code), int'(b.ct_bit)); c.len = 6'(b.ct_bit); tmp.push_back(c); end
        if (b.t1_bit != 0) begin c.code = keep(64'(b.t1_code), int'(b.t1_bit)); c.len = 6'(b.t1_bit); tmp.push_back(c); end
        if (b.lv_bit > 32) begin
            c.code = keep(64'(b.lv_code) >> 32, int'(b.lv_bit) - 32); c.len = 6'(int'(b.lv_bit) - 32); tmp.push_back(c);
        end
        if (b.lv_bit != 0) begin
            lo = (b.lv_bit > 32) ? 32 : int'(b.lv_bit);
            c.code = keep(64'(b.lv_code), lo); c.len = 6'(lo); tmp.push_back(c);
        end
        if (b.tz_bit != 0 && b.tc != 0 && b.tc != 16) begin
            c.code = keep(64'(b.tz_code), int'(b.tz_bit)); c.len = 6'(b.tz_bit); tmp.push_back(c);
        end
        if (b.rb_bit != 0) begin c.code = keep(64'(b.rb_code), int'(b.rb_bit)); c.len = 6'(b.rb_bit); tmp.push_back(c); end
        if (tmp.size() > 0) tmp[tmp.size() - 1].last = 1'b1;
        foreach (tmp[i]) sb_q.push_back(tmp[i]);
    endtask

    // Present a bundle for exactly one accepting edge, then scramble the inputs.
    task automatic send(input bundle_t b);
        int n = 0;
        while (!enc_ready && n < 200) begin @(posedge clk); #1; n++; end
        chk("enc_ready_before_send", 64'(enc_ready), 64'd1);
        drive(b);
        enc_valid = 1'b1;
        @(posedge clk); #1;
        enc_valid = 1'b0;
        drive(rnd_bundle());
        exp_cnt++;
    endtask

    task automatic wait_blocks(input int target, input bit rnd_ready);
        int n = 0;
        while (done_seen < target && n < 2000) begin
            @(posedge clk); #1;
            if (rnd_ready) bs_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        bs_ready = 1'b1;
        chk("blocks_done", 64'(done_seen), 64'(target));
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        chk("blk_cnt", 64'(blk_cnt), 64'(exp_cnt[15:0]));
    endtask

    // Output monitor: scoreboard pops, stall stability, pulse width.
    initial begin
        chunk_t e;
        logic   stall_q = 1'b0;
        logic   prev_done = 1'b0;
        logic [38:0] held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_q = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (blk_done) begin
                    done_seen++;
                    chk("done_pulse_width", 64'(prev_done), 64'd0);
                end
                if (stall_q)
                    chk("stall_hold", 64'({bs_valid, bs_code, bs_len, bs_last}), 64'({1'b1, held}));
                if (bs_valid && bs_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_chunk_valid", 64'(bs_valid), 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("chunk", 64'({bs_code, bs_len, bs_last}), 64'(e));
                    end
                end
                stall_q = bs_valid && !bs_ready;
                held = {bs_code, bs_len, bs_last};
                prev_done = blk_done;
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bundle_t b;
        int      start, n, nblk;
        rst = 1'b1; enc_valid = 1'b0; bs_ready = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bs_valid", 64'(bs_valid), 64'd0);
        chk("rst_bs_last", 64'(bs_last), 64'd0);
        chk("rst_blk_done", 64'(blk_done), 64'd0);
        chk("rst_bs_code", 64'(bs_code), 64'd0);
        chk("rst_bs_len", 64'(bs_len), 64'd0);
        chk("rst_blk_cnt", 64'(blk_cnt), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_enc_ready", 64'(enc_ready), 64'd1);

        // Reset during the LVL chunk aborts the block
        send(mk(0, 0, 0, 0, 50'h12, 6'd8, 0, 0, 25'h1, 5'd1, 5'd1));
        exp_cnt--;
        chk("abort_lvl_code", 64'({bs_valid, bs_code, bs_len}), 64'({1'b1, 32'h12, 6'd8}));
        rst = 1'b1;
        #1;
        chk("abort_rst_valid_low", 64'(bs_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_bs_valid", 64'(bs_valid), 64'd0);
        chk("abort_blk_cnt", 64'(blk_cnt), 64'd0);
        chk("abort_enc_ready", 64'(enc_ready), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_seen), 64'd0);

        // Full block, timing exact with bs_ready held high
        expect_chunk(32'h5, 6'd6, 1'b0);
        expect_chunk(32'h5, 6'd3, 1'b0);
        expect_chunk(32'h3, 6'd2, 1'b0);
        expect_chunk(32'h1, 6'd3, 1'b0);
        expect_chunk(32'h2, 6'd2, 1'b1);
        send(mk(16'h5, 5'd6, 3'b101, 4'd3, 50'h3, 6'd2, 9'h1, 4'd3, 25'h2, 5'd2, 5'd5));
        chk("full_first_latency", 64'(bs_valid), 64'd1);
        repeat (5) begin @(posedge clk); #1; end
        chk("full_done_cycle", 64'(blk_done), 64'd1);
        chk("full_done_no_ready", 64'(enc_ready), 64'd0);
        @(posedge clk); #1;
        chk("full_done_one_cycle", 64'(blk_done), 64'd0);
        wait_blocks(1, 1'b0);

        // Long level spanning LVH and LVL
        expect_chunk(32'hAB, 6'd8, 1'b0);
        expect_chunk(32'h12345678, 6'd32, 1'b1);
        send(mk(0, 0, 0, 0, 50'hAB_1234_5678, 6'd40, 0, 0, 0, 0, 5'd3));
        wait_blocks(2, 1'b0);

        // Level boundaries: exactly 32 bits, and 33 bits
        expect_chunk(32'hDEADBEEF, 6'd32, 1'b1);
        send(mk(0, 0, 0, 0, 50'hDEADBEEF, 6'd32, 0, 0, 0, 0, 5'd2));
        wait_blocks(3, 1'b0);
        expect_chunk(32'h1, 6'd1, 1'b0);
        expect_chunk(32'hCAFEF00D, 6'd32, 1'b1);
        send(mk(0, 0, 0, 0, 50'h1_CAFE_F00D, 6'd33, 0, 0, 0, 0, 5'd2));
        wait_blocks(4, 1'b0);

        // Skips: TotalCoeff 0 and 16 suppress total_zeros
        expect_chunk(32'h1, 6'd1, 1'b1);
        send(mk(16'h1, 5'd1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0));
        wait_blocks(5, 1'b0);
        expect_chunk(32'h1, 6'd1, 1'b1);
        send(mk(16'h1, 5'd1, 0, 0, 0, 0, 9'h3, 4'd2, 0, 0, 5'd0));
        wait_blocks(6, 1'b0);
        expect_chunk(32'h3, 6'd2, 1'b0);
        expect_chunk(32'h1, 6'd1, 1'b1);
        send(mk(16'h3, 5'd2, 0, 0, 0, 0, 9'h5, 4'd4, 25'h1, 5'd1, 5'd16));
        wait_blocks(7, 1'b0);

        // Backpressure on the T1 chunk
        expect_chunk(32'h2, 6'd2, 1'b0);
        expect_chunk(32'h6, 6'd3, 1'b0);
        expect_chunk(32'h1, 6'd1, 1'b1);
        send(mk(16'h2, 5'd2, 3'b110, 4'd3, 0, 0, 0, 0, 25'h1, 5'd1, 5'd2));
        @(posedge clk); #1;
        bs_ready = 1'b0;
        chk("bp_t1_chunk", 64'({bs_code, bs_len}), 64'({32'h6, 6'd3}));
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_t1_hold", 64'({bs_valid, bs_code, bs_len}), 64'({1'b1, 32'h6, 6'd3}));
            chk("bp_enc_ready", 64'(enc_ready), 64'd0);
        end
        bs_ready = 1'b1;
        wait_blocks(8, 1'b0);

        // Randomized bundles with random writer backpressure
        for (int i = 0; i < 30; i++) begin
            b = rnd_bundle();
            model_push(b);
            send(b);
            wait_blocks(exp_cnt, 1'b1);
        end

        // Empty blocks back to back until the counter wraps
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd4));
        nblk = 65536 - (exp_cnt % 65536);
        start = done_seen;
        n = 0;
        enc_valid = 1'b1;
        while (done_seen < start + nblk && n < 3 * nblk) begin
            @(posedge clk); n++;
        end
        #1;
        enc_valid = 1'b0;
        exp_cnt += nblk;
        chk("wrap_done_pulses", 64'(done_seen - start), 64'(nblk));
        chk("wrap_cycles", 64'(n), 64'(2 * nblk));
        chk("wrap_blk_cnt", 64'(blk_cnt), 64'd0);
        chk("wrap_no_chunks", 64'(sb_q.size()), 64'd0);

        // Normal block after wrap
        expect_chunk(32'h7, 6'd3, 1'b1);
        send(mk(16'h7, 5'd3, 0, 0, 0, 0, 0, 0, 0, 0, 5'd1));
        wait_blocks(done_seen + 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
